// File: rtl/img_pkg.sv
// Shared image-stream definitions: default geometry, stream-stage states and
// binary pixel levels.
package img_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int CW_DEF    = 10;

  localparam int         FG_BIT = 0;
  localparam logic [7:0] BIN_LO = 8'd0;
  localparam logic [7:0] BIN_HI = 8'd255;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    REPORT
  } bbox_state_t;

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster coordinate tracker: registered sync edges, x/y position of the
// current pixel and the in-frame acceptance qualifier.
module pixel_coord_counter
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk_i,
  input  logic          a_rst_i,
  input  logic          i_vsyn,
  input  logic          i_en,
  input  logic          i_active,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_accept,
  output logic          o_rise_vs,
  output logic          o_fall_en
);

  localparam logic [CW:0] W_LIM = (CW + 1)'(IMG_W);
  localparam logic [CW:0] H_LIM = (CW + 1)'(IMG_H);

  logic vs_d;
  logic en_d;

  assign o_rise_vs = i_vsyn & ~vs_d;
  assign o_fall_en = ~i_en & en_d;

  assign o_accept = i_en & ~i_vsyn & i_active
                  & ({1'b0, o_x} < W_LIM) & ({1'b0, o_y} < H_LIM);

  always_ff @(posedge clk_i) begin
    if (!a_rst_i) begin
      vs_d <= 1'b0;
      en_d <= 1'b0;
      o_x  <= '0;
      o_y  <= '0;
    end else begin
      vs_d <= i_vsyn;
      en_d <= i_en;
      // Holding at zero outside ACTIVE gives the clear-on-entry behaviour.
      if (!i_active) begin
        o_x <= '0;
        o_y <= '0;
      end else if (o_fall_en) begin
        o_x <= '0;
        o_y <= (o_y == '1) ? o_y : o_y + 1'b1;
      end else if (i_en) begin
        o_x <= (o_x == '1) ? o_x : o_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/binary_bbox_locator.sv
// Per-frame bounding box and centre of foreground pixels in a binary stream.
// Optional BBOX_MIN_AREA_EN: detections below MIN_PIXELS are reported as not found.
module binary_bbox_locator
  import img_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int CW         = CW_DEF,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic             clk_i,
  input  logic             a_rst_i,
  input  logic             i_hsyn,
  input  logic             i_vsyn,
  input  logic             i_en,
  input  logic [7:0]       i_binary,
  output logic             o_valid,
  output logic             o_found,
  output logic [CW-1:0]    o_x_min,
  output logic [CW-1:0]    o_x_max,
  output logic [CW-1:0]    o_y_min,
  output logic [CW-1:0]    o_y_max,
  output logic [CW-1:0]    o_cx,
  output logic [CW-1:0]    o_cy,
  output logic [CNT_W-1:0] o_pix_cnt
);

  bbox_state_t state, state_nxt;

  logic [CW-1:0]    cur_x, cur_y;
  logic             accept, rise_vs, fall_en;
  logic [CW-1:0]    acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [CNT_W-1:0] acc_cnt;
  logic             fg_hit;
  logic             found_c;
  logic [CW:0]      sum_x, sum_y;

  pixel_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_coord (
    .clk_i     (clk_i),
    .a_rst_i   (a_rst_i),
    .i_vsyn    (i_vsyn),
    .i_en      (i_en),
    .i_active  (state == ACTIVE),
    .o_x       (cur_x),
    .o_y       (cur_y),
    .o_accept  (accept),
    .o_rise_vs (rise_vs),
    .o_fall_en (fall_en)
  );

  assign fg_hit = accept & i_binary[FG_BIT];

  always_ff @(posedge clk_i) begin
    if (!a_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise_vs) state_nxt = ACTIVE;
      ACTIVE:  if (rise_vs) state_nxt = REPORT;
      REPORT:  state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!a_rst_i || state != ACTIVE) begin
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
      acc_cnt   <= '0;
    end else if (fg_hit) begin
      // A zero count marks the first foreground pixel; saturation never wraps it back.
      if (acc_cnt == '0) begin
        acc_x_min <= cur_x;
        acc_x_max <= cur_x;
        acc_y_min <= cur_y;
        acc_y_max <= cur_y;
      end else begin
        if (cur_x < acc_x_min) acc_x_min <= cur_x;
        if (cur_x > acc_x_max) acc_x_max <= cur_x;
        if (cur_y < acc_y_min) acc_y_min <= cur_y;
        if (cur_y > acc_y_max) acc_y_max <= cur_y;
      end
      acc_cnt <= (acc_cnt == '1) ? acc_cnt : acc_cnt + 1'b1;
    end
  end

`ifdef BBOX_MIN_AREA_EN
  assign found_c = (32'(acc_cnt) >= 32'(MIN_PIXELS));
  logic unused_ok;
  assign unused_ok = ^{i_hsyn, i_binary};
`else
  assign found_c = |acc_cnt;
  logic unused_ok;
  assign unused_ok = ^{i_hsyn, i_binary, MIN_PIXELS[0]};
`endif

  assign sum_x = {1'b0, acc_x_min} + {1'b0, acc_x_max};
  assign sum_y = {1'b0, acc_y_min} + {1'b0, acc_y_max};

  always_ff @(posedge clk_i) begin
    if (!a_rst_i) begin
      o_valid   <= 1'b0;
      o_found   <= 1'b0;
      o_x_min   <= '0;
      o_x_max   <= '0;
      o_y_min   <= '0;
      o_y_max   <= '0;
      o_cx      <= '0;
      o_cy      <= '0;
      o_pix_cnt <= '0;
    end else begin
      o_valid <= (state == REPORT);
      if (state == REPORT) begin
        o_found   <= found_c;
        o_x_min   <= found_c ? acc_x_min   : '0;
        o_x_max   <= found_c ? acc_x_max   : '0;
        o_y_min   <= found_c ? acc_y_min   : '0;
        o_y_max   <= found_c ? acc_y_max   : '0;
        o_cx      <= found_c ? sum_x[CW:1] : '0;
        o_cy      <= found_c ? sum_y[CW:1] : '0;
        o_pix_cnt <= acc_cnt;
      end
    end
  end

endmodule

// File: doc/binary_bbox_locator.md
Name: binary_bbox_locator

Overview:
- Sits directly downstream of the binary dilation stage in the eye-tracking pipeline.
- Consumes the dilated binary pixel stream and its syncs, and tracks the bounding box of all foreground pixels in each frame.
- At every frame boundary it reports the box and its centre, which serves as the pupil-position estimate for the gaze logic.

Parameters:
IMG_W, 640, active pixels per line; x positions >= IMG_W are ignored
IMG_H, 480, active lines per frame; y positions >= IMG_H are ignored
CW, 10, coordinate width; must satisfy 2^CW >= max(IMG_W, IMG_H)
CNT_W, 20, foreground pixel counter width
MIN_PIXELS, 16, minimum foreground count for a valid detection (used only with the optional feature)

Ports:
clk_i  in  1  pixel clock
a_rst_i  in  1  reset; synchronous, active-low
i_hsyn  in  1  horizontal sync; passed through only, not used for counting
i_vsyn  in  1  vertical sync, active high; its rising edge marks the frame boundary
i_en  in  1  pixel-valid strobe
i_binary  in  8  binary pixel (0 or 255); foreground when bit 0 = 1
o_valid  out  1  one-cycle pulse: result registers have been updated
o_found  out  1  at least one qualifying foreground pixel in the last frame
o_x_min  out  CW  leftmost foreground column
o_x_max  out  CW  rightmost foreground column
o_y_min  out  CW  top foreground line
o_y_max  out  CW  bottom foreground line
o_cx  out  CW  horizontal centre, (x_min + x_max) >> 1
o_cy  out  CW  vertical centre, (y_min + y_max) >> 1
o_pix_cnt  out  CNT_W  foreground pixel count of the last frame

Behaviour:
- Reset (a_rst_i = 0 sampled on a clk_i edge):
  - All outputs go to 0; state goes to IDLE.
  - Reset mid-frame discards the partial frame; no report is issued for it.
- Edge detection: i_vsyn and i_en are each registered once; rise_vs = i_vsyn & ~vs_d and fall_en = ~i_en & en_d.
- State machine:
  - IDLE: wait for rise_vs, then go to ACTIVE with accumulators cleared. No report on this first edge.
  - ACTIVE: accumulate pixels. On rise_vs, go to REPORT.
  - REPORT (one cycle): latch results into the output registers, clear the accumulators, go to ACTIVE.
- Counters:
  - x counts accepted i_en cycles within a line.
  - fall_en sets x to 0 and increments y.
  - Entering ACTIVE sets x = 0 and y = 0.
  - x and y both saturate at 2^CW - 1.
- Pixel acceptance:
  - Accept when i_en = 1, i_vsyn = 0, x < IMG_W, y < IMG_H, and state = ACTIVE.
  - Pixels with i_vsyn = 1 are ignored, including a pixel that coincides with rise_vs.
- Accumulators:
  - On an accepted foreground pixel: min/max registers update, and cnt increments, saturating at 2^CNT_W - 1.
  - On the first foreground pixel of a frame, min and max are both loaded with the current coordinate.
- Latency: o_valid is high for exactly one cycle, 2 clocks after the cycle in which i_vsyn is first sampled high. Results appear in the same cycle and are held until the next report.
- Empty frame: o_found = 0, all coordinates = 0, o_pix_cnt = 0, and o_valid still pulses.
- Centre arithmetic: the sum is computed in CW+1 bits and then shifted right by 1 (truncation), so there is no overflow.
- A rise_vs arriving mid-line still terminates the frame normally.

Optional Feature:
- Macro: BBOX_MIN_AREA_EN
- Defined: o_found = 1 only if the pixel count >= MIN_PIXELS. Below that threshold, coordinates and centre are forced to 0, while o_pix_cnt still reports the true count. This rejects noise specks.
- Undefined: o_found = (count != 0); MIN_PIXELS is unused.

Decomposition:
- Shared package (img_pkg):
  - Default IMG_W, IMG_H, CW.
  - State enum IDLE/ACTIVE/REPORT.
  - Foreground-bit index constant (0).
  - Binary level constants 8'd0 and 8'd255.
- Natural sub-module: pixel_coord_counter. It generates x, y, the accept qualifier and the edge strobes; it is reusable by other stream stages.

Test Plan:
- Single pixel: 8x4 frame (IMG_W = 8, IMG_H = 4), one foreground at (5,2). Expect o_valid pulse, o_found = 1, x_min = x_max = 5, y_min = y_max = 2, cx = 5, cy = 2, o_pix_cnt = 1.
- Block: foreground rectangle x = 100..139, y = 200..229 in a 640x480 frame. Expect box 100/139/200/229, cx = 119, cy = 214, cnt = 1200.
- Empty frame, then reset:
  - All-zero frame: expect o_valid pulse, o_found = 0, all coordinates 0.
  - Assert a_rst_i mid-next-frame: outputs 0, and no o_valid until two vsync rises have been seen.
- Boundaries and saturation:
  - Foreground at x = 639, plus extra pixels at x >= 640 and x = 0: expect x_min = 0, x_max = 639; out-of-range pixels not counted.
  - CNT_W = 4 with 20 foreground pixels: expect cnt saturated at 15.
- Vsync handling: a foreground pixel asserted in the same cycle as the vsync rise is ignored; o_valid goes high exactly 2 cycles after vsync is first sampled high.
- BBOX_MIN_AREA_EN with MIN_PIXELS = 16:
  - 15 foreground pixels: expect o_found = 0, coordinates 0, cnt = 15.
  - 16 foreground pixels: expect o_found = 1 and the true box.
